gate_response_misr: RTL and testbench
=====================================

// Module: gate_response_misr
// PURPOSE
//  Downstream capture stage for the gate-model netlist under test. Consumes the
//  10-bit output vector of the netlist, one vector per applied pattern, and
//  compacts it into a multiple-input signature register (MISR). After a
//  programmed number of patterns it presents the final signature to the lab
//  bench/host, and optionally a pass/fail verdict against a golden value.
// PARAMETERS
//  RESP_W  10        width of the response vector (netlist output count)
//  SIG_W   16        MISR width; must be >= RESP_W
//  POLY    16'h1021  feedback taps; the x^SIG_W term is implicit
//  SEED    16'h0000  MISR value loaded on start
//  CNT_W   16        width of the pattern counter and num_patterns_i
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  start_i         in   1      begin a new compaction run
//  num_patterns_i  in   CNT_W  patterns per run, latched on start
//  resp_i          in   RESP_W netlist response vector
//  resp_valid_i    in   1      resp_i holds a valid pattern response
//  resp_ready_o    out  1      block accepts a response this cycle
//  busy_o          out  1      run in progress
//  done_o          out  1      run complete, signature_o final
//  count_o         out  CNT_W  responses accepted in the current run
//  signature_o     out  SIG_W  current MISR contents
//  golden_i        in   SIG_W  expected signature (GOLDEN_CMP_EN only)
//  pass_o          out  1      signature_o == golden_i at done (GOLDEN_CMP_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE; resp_ready_o=0, busy_o=0, done_o=0,
//    count_o=0, signature_o=SEED, pass_o=0. Reset mid-run aborts; no partial result is kept.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE/DONE --start_i--> RUN: signature<=SEED, count<=0, done_o<=0, pass_o<=0,
//      latch num_patterns_i. If the latched value is 0, go to DONE on the next cycle
//      with signature=SEED.
//    RUN: resp_ready_o=1, busy_o=1. A response is accepted iff
//      resp_valid_i && resp_ready_o. On each accept:
//      sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0,resp_i}; count++.
//    RUN --accept with count==N-1--> DONE, reached on the clock edge of that accept.
//    DONE: done_o=1 (level), busy_o=0, resp_ready_o=0; signature_o and count_o hold.
//  - Latency: signature_o reflects an accepted response 1 cycle after the accept.
//    done_o rises in the same cycle that signature_o holds the final value.
//  - start_i in RUN is ignored. resp_valid_i outside RUN is ignored.
//    A response presented in the same cycle as start_i is not captured.
//  - resp_i is zero-extended to SIG_W. Count is taken modulo 2^CNT_W.
//    N = 2^CNT_W-1 is the maximum run length.
//  - resp_valid_i may drop for any number of cycles in RUN (gaps).
//    The MISR and the counter hold during a gap.
// CONFIGURATION
//  GOLDEN_CMP_EN defined: golden_i and pass_o exist. pass_o is registered on
//    entry to DONE as (final signature == golden_i sampled that cycle). pass_o
//    holds through DONE and clears on start_i or rst.
//  GOLDEN_CMP_EN undefined: golden_i, pass_o and the comparator are absent.
//    The verdict is made off-block from signature_o.
// TESTING
//  1 rst, start N=1, resp=10'h001 -> done_o after 1 accept, signature_o=16'h0001, count_o=1
//  2 start N=2, resp 10'h001 then 10'h001 -> signature_o=16'h0003, count_o=2, busy_o low in DONE
//  3 SEED=16'h8000, N=1, resp=10'h000 -> signature_o=16'h1021 (MSB feedback exercised)
//  4 N=3 with 2-cycle valid gaps, and start_i pulsed mid-run -> same signature as the
//    gap-free run; the mid-run start has no effect
//  5 start N=0 -> done_o on the next cycle, signature_o=SEED, count_o=0;
//    rst asserted mid-run -> all outputs at reset values the next cycle
//  6 GOLDEN_CMP_EN: case 2 with golden_i=16'h0003 -> pass_o=1;
//    with golden_i=16'h0002 -> pass_o=0

Source files
------------

// File: rtl/gate_response_misr_if.sv
// rtl/gate_response_misr_if.sv - response handshake between the netlist driver and the MISR
//
// Purpose: carries one netlist response vector per pattern with a valid/ready
// handshake. A response transfers on a cycle where resp_valid_i && resp_ready_o.
// Signals:
//   resp_i        RESP_W  response vector from the netlist under test
//   resp_valid_i  1       resp_i holds a valid pattern response
//   resp_ready_o  1       the capture stage accepts a response this cycle
// Modports: master (netlist/driver side), slave (capture stage side).
interface gate_response_misr_if #(
  parameter int RESP_W = 10
);
  logic [RESP_W-1:0] resp_i;
  logic              resp_valid_i;
  logic              resp_ready_o;

  modport master (
    output resp_i,
    output resp_valid_i,
    input  resp_ready_o
  );

  modport slave (
    input  resp_i,
    input  resp_valid_i,
    output resp_ready_o
  );
endinterface

// File: rtl/gate_response_misr.sv
// rtl/gate_response_misr.sv - MISR compaction of netlist responses over a programmed run
//
// Purpose: compacts one RESP_W-bit response per accepted pattern into a SIG_W-bit
// multiple-input signature register and presents the final signature after
// num_patterns_i accepts.
// Optional feature macro: GOLDEN_CMP_EN (adds golden_i and pass_o).
// Ports:
//   clk             in   1      rising-edge clock
//   rst             in   1      synchronous active-high reset
//   start_i         in   1      begin a run (ignored while a run is in progress)
//   num_patterns_i  in   CNT_W  patterns per run, latched on start
//   resp_if         slave       response handshake (resp_i, resp_valid_i, resp_ready_o)
//   busy_o          out  1      run in progress
//   done_o          out  1      run complete, signature_o final
//   count_o         out  CNT_W  responses accepted in the current run
//   signature_o     out  SIG_W  current MISR contents
//   golden_i        in   SIG_W  expected signature (GOLDEN_CMP_EN)
//   pass_o          out  1      final signature matched golden_i (GOLDEN_CMP_EN)
module gate_response_misr #(
  parameter int               RESP_W = 10,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int               CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_patterns_i,
  gate_response_misr_if.slave  resp_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     count_o,
`ifdef GOLDEN_CMP_EN
  input  logic [SIG_W-1:0]     golden_i,
  output logic                 pass_o,
`endif
  output logic [SIG_W-1:0]     signature_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] resp_ext;
  logic             start_take;
  logic             accept;

  // A zero-length run spends one cycle in RUN without accepting anything,
  // so ready is held low for it.
  assign resp_if.resp_ready_o = (state_q == RUN) && (num_q != '0);
  assign accept               = resp_if.resp_ready_o && resp_if.resp_valid_i;
  assign start_take           = (state_q != RUN) && start_i;

  always_comb begin
    resp_ext                = '0;
    resp_ext[RESP_W-1:0]    = resp_if.resp_i;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_patterns_i;
        end
      end
      RUN: begin
        if (num_q == '0) begin
          state_d = DONE;
        end else if (accept) begin
          sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == num_q - CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

`ifdef GOLDEN_CMP_EN
  logic pass_q, pass_d;

  // The verdict is taken against the signature that DONE will hold, using
  // golden_i as sampled on the entry edge.
  always_comb begin
    pass_d = pass_q;
    if (start_take) begin
      pass_d = 1'b0;
    end else if ((state_q == RUN) && (state_d == DONE)) begin
      pass_d = (sig_d == golden_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass_o = pass_q;
`endif

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign count_o     = cnt_q;
  assign signature_o = sig_q;

endmodule

// File: tb/tb_gate_response_misr.sv
// tb/tb_gate_response_misr.sv - directed self-checking bench for gate_response_misr
module tb_gate_response_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num = 16'd0;
  logic [9:0]  resp = 10'd0;
  logic        valid = 1'b0;

  logic        busy0, done0, busy1, done1;
  logic [15:0] count0, count1, sig0, sig1;
`ifdef GOLDEN_CMP_EN
  logic [15:0] golden0 = 16'd0;
  logic [15:0] golden1 = 16'd0;
  logic        pass0, pass1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_response_misr_if #(.RESP_W(10)) u_if0 ();
  gate_response_misr_if #(.RESP_W(10)) u_if1 ();

  assign u_if0.resp_i       = resp;
  assign u_if0.resp_valid_i = valid;
  assign u_if1.resp_i       = resp;
  assign u_if1.resp_valid_i = valid;

  gate_response_misr dut0 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .num_patterns_i (num),
    .resp_if        (u_if0.slave),
    .busy_o         (busy0),
    .done_o         (done0),
    .count_o        (count0),
`ifdef GOLDEN_CMP_EN
    .golden_i       (golden0),
    .pass_o         (pass0),
`endif
    .signature_o    (sig0)
  );

  gate_response_misr #(.SEED(16'h8000)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .num_patterns_i (num),
    .resp_if        (u_if1.slave),
    .busy_o         (busy1),
    .done_o         (done1),
    .count_o        (count1),
`ifdef GOLDEN_CMP_EN
    .golden_i       (golden1),
    .pass_o         (pass1),
`endif
    .signature_o    (sig1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [9:0] r);
    int waited = 0;
    resp  = r;
    valid = 1'b1;
    while (!u_if0.resp_ready_o && waited < 10) begin
      tick();
      waited++;
    end
    if (!u_if0.resp_ready_o) check("ready_timeout", 32'd0, 32'd1);
    tick();
    valid = 1'b0;
    resp  = 10'h2A5;
  endtask

  task automatic gap(input int n);
    valid = 1'b0;
    resp  = 10'h3C3;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {31'd0, u_if0.resp_ready_o}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy0}, 32'd0);
    check({tag, "_done"},  {31'd0, done0}, 32'd0);
    check({tag, "_count"}, {16'd0, count0}, 32'd0);
    check({tag, "_sig0"},  {16'd0, sig0}, 32'h0000);
    check({tag, "_sig1"},  {16'd0, sig1}, 32'h8000);
`ifdef GOLDEN_CMP_EN
    check({tag, "_pass"},  {31'd0, pass0}, 32'd0);
`endif
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst");

    // 1: single pattern
    do_start(16'd1);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    check("t1_done_pre", {31'd0, done0}, 32'd0);
    send(10'h001);
    check("t1_done", {31'd0, done0}, 32'd1);
    check("t1_sig", {16'd0, sig0}, 32'h0001);
    check("t1_count", {16'd0, count0}, 32'd1);
    check("t1_ready", {31'd0, u_if0.resp_ready_o}, 32'd0);

    // 2: two patterns, result holds in DONE, valid in DONE ignored
    do_start(16'd2);
    check("t2_count0", {16'd0, count0}, 32'd0);
    check("t2_sig0", {16'd0, sig0}, 32'h0000);
    send(10'h001);
    check("t2_mid_done", {31'd0, done0}, 32'd0);
    send(10'h001);
    check("t2_sig", {16'd0, sig0}, 32'h0003);
    check("t2_count", {16'd0, count0}, 32'd2);
    check("t2_busy", {31'd0, busy0}, 32'd0);
    resp  = 10'h3FF;
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    check("t2_hold_sig", {16'd0, sig0}, 32'h0003);
    check("t2_hold_count", {16'd0, count0}, 32'd2);

    // 3: MSB feedback on the SEED=0x8000 instance
    do_start(16'd1);
    send(10'h000);
    check("t3_sig_seed0", {16'd0, sig0}, 32'h0000);
    check("t3_sig_seed8000", {16'd0, sig1}, 32'h1021);
    check("t3_done1", {31'd0, done1}, 32'd1);

    // 4: gap-free reference run
    do_start(16'd3);
    send(10'h123);
    check("t4_s1", {16'd0, sig0}, 32'h0123);
    send(10'h045);
    check("t4_s2", {16'd0, sig0}, 32'h0203);
    send(10'h3FF);
    check("t4_sig", {16'd0, sig0}, 32'h07F9);
    check("t4_done", {31'd0, done0}, 32'd1);

    // 4b: same vectors with gaps and a mid-run start
    do_start(16'd3);
    send(10'h123);
    gap(1);
    start = 1'b1;
    num   = 16'd5;
    tick();
    start = 1'b0;
    check("t4b_gap_count", {16'd0, count0}, 32'd1);
    check("t4b_gap_sig", {16'd0, sig0}, 32'h0123);
    check("t4b_gap_busy", {31'd0, busy0}, 32'd1);
    send(10'h045);
    gap(2);
    send(10'h3FF);
    check("t4b_sig", {16'd0, sig0}, 32'h07F9);
    check("t4b_count", {16'd0, count0}, 32'd3);
    check("t4b_done", {31'd0, done0}, 32'd1);

    // 5: zero-length run
    do_start(16'd0);
    check("t5_done_pre", {31'd0, done0}, 32'd0);
    tick();
    check("t5_done", {31'd0, done0}, 32'd1);
    check("t5_sig0", {16'd0, sig0}, 32'h0000);
    check("t5_sig1", {16'd0, sig1}, 32'h8000);
    check("t5_count", {16'd0, count0}, 32'd0);

    // 5b: reset mid-run
    do_start(16'd3);
    send(10'h123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");

`ifdef GOLDEN_CMP_EN
    // 6: golden compare
    golden0 = 16'h0003;
    golden1 = 16'h0000;
    do_start(16'd2);
    send(10'h001);
    send(10'h001);
    check("t6_pass", {31'd0, pass0}, 32'd1);
    check("t6_pass1", {31'd0, pass1}, 32'd0);
    golden0 = 16'h0002;
    do_start(16'd2);
    check("t6_pass_clr", {31'd0, pass0}, 32'd0);
    send(10'h001);
    send(10'h001);
    check("t6_fail", {31'd0, pass0}, 32'd0);
    check("t6_sig", {16'd0, sig0}, 32'h0003);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
